// File: rtl/regfile_port_sequencer_if.sv
// Decode, operand, writeback and register-file port bundle for regfile_port_sequencer.
// master = sequencer side, slave = surrounding pipeline / register file side.
interface regfile_port_sequencer_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
);
  logic              dec_valid;
  logic              dec_ready;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic              dec_use_rs2;
  logic [REG_AW-1:0] dec_rd;

  logic              op_valid;
  logic              op_ready;
  logic [XLEN-1:0]   op_rs1_data;
  logic [XLEN-1:0]   op_rs2_data;
  logic [REG_AW-1:0] op_rd;

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic [REG_AW-1:0] rf_reg_num;
  logic              rf_write;
  logic [XLEN-1:0]   rf_data_in;
  logic [XLEN-1:0]   rf_data_out;

  modport master (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs2, dec_rd,
    output dec_ready,
    output op_valid, op_rs1_data, op_rs2_data, op_rd,
    input  op_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    output rf_reg_num, rf_write, rf_data_in,
    input  rf_data_out
  );

  modport slave (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs2, dec_rd,
    input  dec_ready,
    input  op_valid, op_rs1_data, op_rs2_data, op_rd,
    output op_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    input  rf_reg_num, rf_write, rf_data_in,
    output rf_data_out
  );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Serialises rs1/rs2 reads and execute writebacks over one register-file port.
// Optional REGSEQ_PERF_EN adds a saturating decode-stall counter (perf_stall_cnt).
module regfile_port_sequencer #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic clk,
  input  logic resetn,
  regfile_port_sequencer_if.master bus,
  output logic busy
`ifdef REGSEQ_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ_RS1, READ_RS2, ISSUE} state_t;

  state_t            state;
  state_t            next_state;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic              use_rs2_q;
  logic [XLEN-1:0]   op_rs1_q;
  logic [XLEN-1:0]   op_rs2_q;
  logic              accept;

  // Writeback wins in IDLE; decode is only taken when no writeback is offered.
  assign accept = (state == IDLE) && bus.dec_valid && !bus.wb_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.dec_ready  = 1'b0;
    bus.wb_ready   = 1'b0;
    bus.op_valid   = 1'b0;
    bus.rf_write   = 1'b0;
    bus.rf_reg_num = '0;
    bus.rf_data_in = '0;
    case (state)
      IDLE: begin
        bus.wb_ready  = 1'b1;
        bus.dec_ready = !bus.wb_valid;
        if (bus.wb_valid) begin
          bus.rf_reg_num = bus.wb_rd;
          bus.rf_data_in = bus.wb_data;
          bus.rf_write   = (bus.wb_rd != '0);
        end else if (bus.dec_valid) begin
          next_state = READ_RS1;
        end
      end
      READ_RS1: begin
        bus.rf_reg_num = rs1_q;
        next_state     = use_rs2_q ? READ_RS2 : ISSUE;
      end
      READ_RS2: begin
        bus.rf_reg_num = rs2_q;
        next_state     = ISSUE;
      end
      ISSUE: begin
        bus.op_valid = 1'b1;
        if (bus.op_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // x0 is forced to zero here rather than trusting the register file contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs2_q <= 1'b0;
      op_rs1_q  <= '0;
      op_rs2_q  <= '0;
    end else begin
      if (accept) begin
        rs1_q     <= bus.dec_rs1;
        rs2_q     <= bus.dec_rs2;
        rd_q      <= bus.dec_rd;
        use_rs2_q <= bus.dec_use_rs2;
      end
      case (state)
        READ_RS1: begin
          op_rs1_q <= (rs1_q == '0) ? '0 : bus.rf_data_out;
          if (!use_rs2_q) op_rs2_q <= '0;
        end
        READ_RS2: op_rs2_q <= (rs2_q == '0) ? '0 : bus.rf_data_out;
        default: ;
      endcase
    end
  end

  assign bus.op_rs1_data = op_rs1_q;
  assign bus.op_rs2_data = op_rs2_q;
  assign bus.op_rd       = rd_q;
  assign busy            = (state != IDLE);

`ifdef REGSEQ_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      perf_stall_cnt <= '0;
    else if (bus.dec_valid && !bus.dec_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Self-checking bench for regfile_port_sequencer: vector table, operand scoreboard,
// and hand-written x0, collision, back-pressure and mid-sequence reset sequences.
module tb_regfile_port_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  logic force_dead = 1'b0;
`ifdef REGSEQ_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_start;
`endif

  int total = 0;
  int bad = 0;

  regfile_port_sequencer_if #(.XLEN(64), .REG_AW(5)) bus ();

  regfile_port_sequencer #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .busy(busy)
`ifdef REGSEQ_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port register file; every entry starts non-zero, x0 included.
  logic [63:0] regs [32] = '{default: 64'hBAD0_0000_DEAD_0000};
  always @(posedge clk) if (bus.rf_write) regs[bus.rf_reg_num] <= bus.rf_data_in;
  assign bus.rf_data_out = force_dead ? 64'hDEAD : regs[bus.rf_reg_num];

  typedef struct {
    bit          is_wb;
    logic [4:0]  a;
    logic [4:0]  b;
    bit          use_rs2;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          exp_write;
    logic [63:0] exp_rs1;
    logic [63:0] exp_rs2;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  function automatic vec_t mk_wb(input logic [4:0] rd, input logic [63:0] data, input bit wr);
    vec_t v;
    v = '{is_wb: 1'b1, a: rd, b: 5'd0, use_rs2: 1'b0, rd: 5'd0, data: data, exp_write: wr,
          exp_rs1: 64'd0, exp_rs2: 64'd0, exp_lat: 0};
    return v;
  endfunction

  function automatic vec_t mk_inst(input logic [4:0] rs1, input logic [4:0] rs2, input bit use2,
                                   input logic [4:0] rd, input logic [63:0] e1, input logic [63:0] e2,
                                   input int lat);
    vec_t v;
    v = '{is_wb: 1'b0, a: rs1, b: rs2, use_rs2: use2, rd: rd, data: 64'd0, exp_write: 1'b0,
          exp_rs1: e1, exp_rs2: e2, exp_lat: lat};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    bus.dec_valid   = 1'b0;
    bus.dec_rs1     = '0;
    bus.dec_rs2     = '0;
    bus.dec_use_rs2 = 1'b0;
    bus.dec_rd      = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
  endtask

  task automatic inst_accept(input logic [4:0] rs1, input logic [4:0] rs2, input bit use2,
                             input logic [4:0] rd, input bit rdy,
                             input logic [63:0] e1, input logic [63:0] e2);
    exp_t e;
    @(negedge clk);
    quiet_inputs();
    bus.dec_valid   = 1'b1;
    bus.dec_rs1     = rs1;
    bus.dec_rs2     = rs2;
    bus.dec_use_rs2 = use2;
    bus.dec_rd      = rd;
    bus.op_ready    = rdy;
    #1;
    checkOutput("dec_ready_accept", 64'(bus.dec_ready), 64'd1);
    e = '{rs1: e1, rs2: e2, rd: rd};
    sb.push_back(e);
  endtask

  // Counts negedges from the accept cycle until op_valid shows up (bounded).
  task automatic wait_issue(input int exp_lat);
    int cyc;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    cyc = 1;
    while (!bus.op_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checkOutput("issue_latency", 64'(cyc), 64'(exp_lat));
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_wb) begin
      @(negedge clk);
      quiet_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = v.a;
      bus.wb_data  = v.data;
      #1;
      checkOutput("wb_ready", 64'(bus.wb_ready), 64'd1);
      checkOutput("wb_dec_ready", 64'(bus.dec_ready), 64'd0);
      checkOutput("wb_rf_write", 64'(bus.rf_write), 64'(v.exp_write));
      checkOutput("wb_rf_reg_num", 64'(bus.rf_reg_num), 64'(v.a));
      checkOutput("wb_rf_data_in", bus.rf_data_in, v.data);
    end else begin
      inst_accept(v.a, v.b, v.use_rs2, v.rd, 1'b1, v.exp_rs1, v.exp_rs2);
      wait_issue(v.exp_lat);
    end
  endtask

  // Scoreboard: compare operands on every op handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (resetn && bus.op_valid && bus.op_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_underflow: got unexpected op rd=%0d expected none", bus.op_rd);
      end else begin
        e = sb.pop_front();
        checkOutput("op_rs1_data", bus.op_rs1_data, e.rs1);
        checkOutput("op_rs2_data", bus.op_rs2_data, e.rs2);
        checkOutput("op_rd", 64'(bus.op_rd), 64'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    quiet_inputs();
    bus.op_ready = 1'b0;

    tbl[0] = mk_wb(5'd5,  64'h1234, 1'b1);
    tbl[1] = mk_wb(5'd0,  64'hFFFF, 1'b0);
    tbl[2] = mk_wb(5'd3,  64'hA5, 1'b1);
    tbl[3] = mk_wb(5'd31, 64'hCAFE_F00D_0000_0001, 1'b1);
    tbl[4] = mk_inst(5'd5,  5'd5,  1'b1, 5'd7,  64'h1234, 64'h1234, 3);
    tbl[5] = mk_inst(5'd3,  5'd5,  1'b0, 5'd1,  64'hA5, 64'h0, 2);
    tbl[6] = mk_inst(5'd0,  5'd31, 1'b1, 5'd2,  64'h0, 64'hCAFE_F00D_0000_0001, 3);
    tbl[7] = mk_inst(5'd31, 5'd0,  1'b1, 5'd31, 64'hCAFE_F00D_0000_0001, 64'h0, 3);
    tbl[8] = mk_wb(5'd5,  64'h5555, 1'b1);
    tbl[9] = mk_inst(5'd5,  5'd3,  1'b1, 5'd0,  64'h5555, 64'hA5, 3);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_op_valid", 64'(bus.op_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_dec_ready", 64'(bus.dec_ready), 64'd1);
    checkOutput("rst_wb_ready", 64'(bus.wb_ready), 64'd1);
    checkOutput("rst_rf_write", 64'(bus.rf_write), 64'd0);
    checkOutput("rst_op_rs1", bus.op_rs1_data, 64'd0);
    checkOutput("rst_op_rd", 64'(bus.op_rd), 64'd0);
`ifdef REGSEQ_PERF_EN
    checkOutput("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);

    // x0 reads must be zero even when the register file returns garbage.
    force_dead = 1'b1;
    inst_accept(5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 64'h0, 64'h0);
    wait_issue(3);
    @(negedge clk);
    force_dead = 1'b0;

    // Writeback and decode offered together: writeback first, decode next cycle.
    quiet_inputs();
    bus.wb_valid    = 1'b1;
    bus.wb_rd       = 5'd9;
    bus.wb_data     = 64'h99;
    bus.dec_valid   = 1'b1;
    bus.dec_rs1     = 5'd9;
    bus.dec_rs2     = 5'd9;
    bus.dec_use_rs2 = 1'b1;
    bus.dec_rd      = 5'd4;
    #1;
    checkOutput("coll_dec_ready", 64'(bus.dec_ready), 64'd0);
    checkOutput("coll_rf_write", 64'(bus.rf_write), 64'd1);
    checkOutput("coll_wb_ready", 64'(bus.wb_ready), 64'd1);
    inst_accept(5'd9, 5'd9, 1'b1, 5'd4, 1'b1, 64'h99, 64'h99);
    wait_issue(3);

    // Back-pressure: operands hold while execute stalls; port stays closed.
    inst_accept(5'd3, 5'd0, 1'b0, 5'd6, 1'b0, 64'hA5, 64'h0);
    wait_issue(2);
`ifdef REGSEQ_PERF_EN
    perf_start = perf_stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      bus.dec_valid = 1'b1;
      bus.wb_valid  = 1'b1;
      bus.wb_rd     = 5'd3;
      bus.wb_data   = 64'hFFFF;
      #1;
      checkOutput("hold_op_valid", 64'(bus.op_valid), 64'd1);
      checkOutput("hold_op_rs1", bus.op_rs1_data, 64'hA5);
      checkOutput("hold_op_rs2", bus.op_rs2_data, 64'h0);
      checkOutput("hold_op_rd", 64'(bus.op_rd), 64'd6);
      checkOutput("hold_dec_ready", 64'(bus.dec_ready), 64'd0);
      checkOutput("hold_wb_ready", 64'(bus.wb_ready), 64'd0);
      checkOutput("hold_rf_write", 64'(bus.rf_write), 64'd0);
      @(negedge clk);
    end
`ifdef REGSEQ_PERF_EN
    checkOutput("perf_stall_delta", 64'(perf_stall_cnt - perf_start), 64'd5);
`endif
    quiet_inputs();
    bus.op_ready = 1'b1;

    // Reset asserted while reading rs2; a fresh instruction must then run normally.
    inst_accept(5'd3, 5'd5, 1'b1, 5'd9, 1'b1, 64'hA5, 64'h5555);
    @(negedge clk);
    bus.dec_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mid_busy", 64'(busy), 64'd1);
    checkOutput("mid_op_rs1", bus.op_rs1_data, 64'hA5);
    resetn = 1'b0;
    #1;
    sb.delete();
    checkOutput("mrst_op_valid", 64'(bus.op_valid), 64'd0);
    checkOutput("mrst_busy", 64'(busy), 64'd0);
    checkOutput("mrst_op_rs1", bus.op_rs1_data, 64'd0);
    checkOutput("mrst_op_rs2", bus.op_rs2_data, 64'd0);
    checkOutput("mrst_op_rd", 64'(bus.op_rd), 64'd0);
    checkOutput("mrst_rf_reg_num", 64'(bus.rf_reg_num), 64'd0);
    checkOutput("mrst_dec_ready", 64'(bus.dec_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    inst_accept(5'd3, 5'd9, 1'b1, 5'd10, 1'b1, 64'hA5, 64'h99);
    wait_issue(3);

    repeat (3) @(negedge clk);
    #3;
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
